// File: rtl/matmul_pkg.sv
// Shared definitions for the systolic matmul datapath: default sizes, sequencer state codes
// and the RUN phase length.
package matmul_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned DIM_DEF        = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    // Operand feed (DIM) plus skew drain (2*DIM-1) through the array.
    function automatic int unsigned run_cycles(input int unsigned dim);
        return 3 * dim - 1;
    endfunction

endpackage

// File: rtl/matmul_step_cnt.sv
// RUN step counter: synchronous clear, enable, saturates on the last step.
// Also decodes the last step and the operand-feed phase (steps 0..DIM-1).
module matmul_step_cnt import matmul_pkg::*; #(
    parameter int unsigned DIM   = DIM_DEF,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] step,
    output logic             last_step,
    output logic             feed_phase
);

    localparam logic [CNT_W-1:0] LAST     = CNT_W'(run_cycles(DIM) - 1);
    localparam logic [CNT_W-1:0] FEED_END = CNT_W'(DIM);

    logic [CNT_W-1:0] step_q, step_d;

    always_comb begin
        step_d = step_q;
        if (clr) begin
            step_d = '0;
        end else if (en && !last_step) begin
            step_d = step_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            step_q <= '0;
        end else begin
            step_q <= step_d;
        end
    end

    assign step       = step_q;
    assign last_step  = (step_q == LAST);
    assign feed_phase = (step_q < FEED_END);

endmodule

// File: rtl/matmul_ctrl.sv
// Job sequencer for a DIM x DIM systolic MAC array: clear, feed, flush, hold results.
// Optional synchronous job abort enabled by defining MATMUL_CTRL_ABORT_EN.
module matmul_ctrl import matmul_pkg::*; #(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned DIM        = DIM_DEF,
    parameter int unsigned CNT_W      = 6
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   res_valid_o,
    output logic                   rd_en_o,
    output logic [$clog2(DIM)-1:0] rd_idx_o,
    output logic                   feed_valid_o,
    output logic                   pe_start_o,
    input  logic [DIM*DIM-1:0]     pe_ovf_i,
    output logic                   ovf_o
`ifdef MATMUL_CTRL_ABORT_EN
    ,
    input  logic                   abort_i
`endif
);

    localparam int unsigned IDX_W = $clog2(DIM);

    if (DATA_WIDTH == 0 || DIM < 2 || DIM > 16 || (1 << CNT_W) <= 3 * DIM) begin : g_param_chk
        $error("matmul_ctrl: illegal DATA_WIDTH/DIM/CNT_W combination");
    end

    logic [1:0]       state_q, state_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] step;
    logic             last_step, feed_phase;
    logic             abort;
    logic             feeding;

`ifdef MATMUL_CTRL_ABORT_EN
    assign abort = abort_i && (state_q == ST_CLEAR || state_q == ST_RUN);
`else
    assign abort = 1'b0;
`endif

    matmul_step_cnt #(
        .DIM   (DIM),
        .CNT_W (CNT_W)
    ) u_step_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr        (state_q == ST_CLEAR),
        .en         (state_q == ST_RUN),
        .step       (step),
        .last_step  (last_step),
        .feed_phase (feed_phase)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_i) state_d = ST_CLEAR;
            ST_CLEAR: state_d = abort ? ST_IDLE : ST_RUN;
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (last_step) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD:  if (start_i) state_d = ST_CLEAR;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Overflow is zeroed as a job is accepted so it already reads 0 during CLEAR.
    always_comb begin
        ovf_d = ovf_q;
        if (state_d == ST_CLEAR || abort) begin
            ovf_d = 1'b0;
        end else if (state_q == ST_RUN) begin
            ovf_d = ovf_q | (|pe_ovf_i);
        end
    end

    assign done_d = (state_q == ST_RUN) && (state_d == ST_HOLD);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign feeding      = (state_q == ST_RUN) && feed_phase;
    assign busy_o       = (state_q == ST_CLEAR) || (state_q == ST_RUN);
    assign done_o       = done_q;
    assign res_valid_o  = (state_q == ST_HOLD) && !start_i;
    assign rd_en_o      = feeding;
    assign rd_idx_o     = feeding ? step[IDX_W-1:0] : '0;
    assign feed_valid_o = feeding;
    assign pe_start_o   = (state_q == ST_RUN) || (state_q == ST_HOLD);
    assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_matmul_ctrl.sv
// Directed, table-driven bench for matmul_ctrl at DIM=4: one vector per clock cycle,
// plus hand-written sequences for HOLD stability, mid-job reset and (optionally) abort.
module tb_matmul_ctrl;
    import matmul_pkg::*;

    localparam int unsigned DIM = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic        busy_o, done_o, res_valid_o, rd_en_o, feed_valid_o, pe_start_o, ovf_o;
    logic [1:0]  rd_idx_o;
    logic [15:0] pe_ovf_i;
`ifdef MATMUL_CTRL_ABORT_EN
    logic        abort_i = 1'b0;
`endif

    always #5 clk_i = ~clk_i;

    matmul_ctrl #(
        .DATA_WIDTH (8),
        .DIM        (DIM),
        .CNT_W      (6)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .res_valid_o  (res_valid_o),
        .rd_en_o      (rd_en_o),
        .rd_idx_o     (rd_idx_o),
        .feed_valid_o (feed_valid_o),
        .pe_start_o   (pe_start_o),
        .pe_ovf_i     (pe_ovf_i),
        .ovf_o        (ovf_o)
`ifdef MATMUL_CTRL_ABORT_EN
        ,
        .abort_i      (abort_i)
`endif
    );

    // Packed outputs: {busy, done, res_valid, rd_en, rd_idx[1:0], feed_valid, pe_start, ovf}
    typedef struct {
        logic        start;
        logic [15:0] ovf_in;
        logic [8:0]  exp;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [8:0] mk(input logic busy, input logic done, input logic rv,
                                      input logic rd, input logic [1:0] idx, input logic fv,
                                      input logic ps, input logic ovf);
        return {busy, done, rv, rd, idx, fv, ps, ovf};
    endfunction

    function automatic logic [8:0] outs();
        return {busy_o, done_o, res_valid_o, rd_en_o, rd_idx_o, feed_valid_o, pe_start_o,
                ovf_o};
    endfunction

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %b want %b (busy,done,rv,rd_en,idx,fv,ps,ovf)",
                     name, got, want);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    // RUN row for step s: operands read on steps 0..3, zero flush afterwards.
    task automatic add_run(input logic start, input int s, input logic [15:0] oin,
                           input logic ovf_exp);
        logic feed;
        feed = (s < DIM);
        tbl.push_back('{start, oin, mk(1, 0, 0, feed, feed ? 2'(s) : 2'd0, feed, 1, ovf_exp)});
    endtask

    initial begin
        rst_ni   = 1'b0;
        start_i  = 1'b1;
        pe_ovf_i = '0;

        // Reset held with start_i=1: everything stays 0 and the FSM sits in IDLE.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            #1;
            check($sformatf("reset%0d", i), outs(), 9'b0);
            check_bit($sformatf("reset_idle%0d", i), dut.state_q == ST_IDLE, 1'b1);
        end

        // Job 1 (cycles 0..15): start ignored throughout RUN, pe_ovf_i[5] pulsed at step 7.
        tbl.push_back('{1'b1, 16'h0, mk(0, 0, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{1'b0, 16'h0, mk(1, 0, 0, 0, 0, 0, 0, 0)});
        for (int s = 0; s <= 10; s++) begin
            add_run(1'b1, s, (s == 7) ? 16'h0020 : 16'h0, s >= 8);
        end
        tbl.push_back('{1'b0, 16'h0, mk(0, 1, 1, 0, 0, 0, 1, 1)});
        tbl.push_back('{1'b0, 16'h0, mk(0, 0, 1, 0, 0, 0, 1, 1)});
        tbl.push_back('{1'b1, 16'h0, mk(0, 0, 0, 0, 0, 0, 1, 1)});
        // Job 2 back-to-back from HOLD: CLEAR at 16, done at 28.
        tbl.push_back('{1'b0, 16'h0, mk(1, 0, 0, 0, 0, 0, 0, 0)});
        for (int s = 0; s <= 10; s++) begin
            add_run(1'b0, s, 16'h0, 1'b0);
        end
        tbl.push_back('{1'b0, 16'h0, mk(0, 1, 1, 0, 0, 0, 1, 0)});
        tbl.push_back('{1'b0, 16'h0, mk(0, 0, 1, 0, 0, 0, 1, 0)});

        @(negedge clk_i);
        rst_ni = 1'b1;
        foreach (tbl[i]) begin
            start_i  = tbl[i].start;
            pe_ovf_i = tbl[i].ovf_in;
            #1;
            check($sformatf("vec%0d", i), outs(), tbl[i].exp);
            @(negedge clk_i);
        end

        // Results must stay stable across a long HOLD.
        start_i  = 1'b0;
        pe_ovf_i = '0;
        for (int i = 0; i < 20; i++) begin
            #1;
            check($sformatf("hold%0d", i), outs(), mk(0, 0, 1, 0, 0, 0, 1, 0));
            @(negedge clk_i);
        end

        // Asynchronous reset mid-job at step 5.
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (6) @(negedge clk_i);
        #1;
        check("pre_rst_step5", outs(), mk(1, 0, 0, 0, 0, 0, 1, 0));
        #2;
        rst_ni = 1'b0;
        #1;
        check("rst_mid_job", outs(), 9'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            #1;
            check($sformatf("post_rst%0d", i), outs(), 9'b0);
        end

`ifdef MATMUL_CTRL_ABORT_EN
        // Abort at step 5 after an overflow at step 2: back to IDLE, no done, ovf cleared.
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int s = 0; s <= 5; s++) begin
            @(negedge clk_i);
            pe_ovf_i = (s == 2) ? 16'h0001 : 16'h0;
            abort_i  = (s == 5);
        end
        #1;
        check("pre_abort", outs(), mk(1, 0, 0, 0, 0, 0, 1, 1));
        @(negedge clk_i);
        abort_i  = 1'b0;
        pe_ovf_i = '0;
        for (int i = 0; i < 15; i++) begin
            #1;
            check($sformatf("post_abort%0d", i), outs(), 9'b0);
            @(negedge clk_i);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
